// File: rtl/ovl_bus_mon_pkg.sv
// Shared types and constants for the tristate bus contention monitor.
package ovl_bus_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_CONTEND = 2'd2,
        ST_QUIET   = 2'd3
    } bus_state_e;

    localparam int FIRE_CONTENTION = 0;
    localparam int FIRE_QUIET      = 1;
    localparam int FIRE_XCHECK     = 2;
    localparam int CNT_W           = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/ovl_bus_enable_decode.sv
// Classifies the driver enable vector as none/one/many and finds the lowest active driver.
module ovl_bus_enable_decode #(
    parameter int NUM_DRIVERS = 4,
    parameter int IDX_W       = (NUM_DRIVERS > 1) ? $clog2(NUM_DRIVERS) : 1
) (
    input  logic [NUM_DRIVERS-1:0] driver_enables,
    output logic                   none,
    output logic                   one,
    output logic                   many,
    output logic [IDX_W-1:0]       index
);

    logic             seen_s;
    logic             multi_s;
    logic [IDX_W-1:0] idx_s;

    // Scan high to low so the last hit is the lowest set index.
    always_comb begin
        seen_s  = 1'b0;
        multi_s = 1'b0;
        idx_s   = {IDX_W{1'b0}};
        for (int i = NUM_DRIVERS - 1; i >= 0; i--) begin
            if (driver_enables[i]) begin
                multi_s = multi_s | seen_s;
                seen_s  = 1'b1;
                idx_s   = IDX_W'(i);
            end else begin
                multi_s = multi_s;
            end
        end
    end

    assign none  = ~seen_s;
    assign one   = seen_s & ~multi_s;
    assign many  = multi_s;
    assign index = idx_s;

endmodule

// File: rtl/ovl_bus_contention_monitor.sv
// Tristate bus contention / handover-quiet-window checker with registered violation pulses.
// Optional X/Z-on-owned-bus check is compiled in with macro OVL_BUS_XCHECK_EN.
module ovl_bus_contention_monitor
    import ovl_bus_mon_pkg::*;
#(
    parameter int NUM_DRIVERS = 4,
    parameter int WIDTH       = 8,
    parameter int MIN_QUIET   = 1,
    parameter int MAX_QUIET   = 0,
    parameter int OW          = (NUM_DRIVERS > 1) ? $clog2(NUM_DRIVERS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       test_expr,
    input  logic [NUM_DRIVERS-1:0] driver_enables,
    output logic [2:0]             fire,
    output logic [OW-1:0]          owner,
    output logic                   owner_valid,
    output logic [CNT_W-1:0]       violation_count
);

    localparam logic [CNT_W-1:0] MIN_Q = CNT_W'(MIN_QUIET);
    localparam logic [CNT_W-1:0] MAX_Q = CNT_W'(MAX_QUIET);

    logic             none_s;
    logic             one_s;
    logic             many_s;
    logic [OW-1:0]    idx_s;
    logic             xz_s;

    bus_state_e       state_r;
    bus_state_e       state_nx_s;
    logic [CNT_W-1:0] qcnt_r;
    logic [CNT_W-1:0] qcnt_nx_s;
    logic [OW-1:0]    owner_r;
    logic [OW-1:0]    owner_nx_s;
    logic             owner_valid_r;
    logic [2:0]       fire_r;
    logic [2:0]       fire_nx_s;
    logic [CNT_W-1:0] count_r;

    ovl_bus_enable_decode #(
        .NUM_DRIVERS (NUM_DRIVERS),
        .IDX_W       (OW)
    ) u_decode (
        .driver_enables (driver_enables),
        .none           (none_s),
        .one            (one_s),
        .many           (many_s),
        .index          (idx_s)
    );

`ifdef OVL_BUS_XCHECK_EN
    assign xz_s = (state_r == ST_OWNED) && one_s && $isunknown(test_expr);
`else
    logic unused_test_expr_s;
    assign unused_test_expr_s = ^test_expr;
    assign xz_s = 1'b0;
`endif

    // Next-state, quiet counter, owner and violation decode.
    always_comb begin
        state_nx_s = state_r;
        qcnt_nx_s  = qcnt_r;
        owner_nx_s = owner_r;
        fire_nx_s  = 3'b000;
        if (many_s) begin
            // Contention always wins regardless of state.
            state_nx_s                 = ST_CONTEND;
            qcnt_nx_s                  = {CNT_W{1'b0}};
            owner_nx_s                 = {OW{1'b0}};
            fire_nx_s[FIRE_CONTENTION] = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (one_s) begin
                        state_nx_s = ST_OWNED;
                        owner_nx_s = idx_s;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_OWNED: begin
                    if (one_s) begin
                        fire_nx_s[FIRE_QUIET] = (idx_s != owner_r) && (MIN_QUIET > 0);
                        owner_nx_s            = idx_s;
                    end else begin
                        state_nx_s = ST_QUIET;
                        qcnt_nx_s  = {{(CNT_W-1){1'b0}}, 1'b1};
                        owner_nx_s = {OW{1'b0}};
                    end
                end
                ST_CONTEND: begin
                    if (one_s) begin
                        state_nx_s = ST_OWNED;
                        owner_nx_s = idx_s;
                    end else begin
                        state_nx_s = ST_QUIET;
                        qcnt_nx_s  = {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_QUIET: begin
                    if (one_s) begin
                        state_nx_s            = ST_OWNED;
                        owner_nx_s            = idx_s;
                        qcnt_nx_s             = {CNT_W{1'b0}};
                        fire_nx_s[FIRE_QUIET] = (qcnt_r < MIN_Q);
                    end else if ((MAX_QUIET > 0) && (qcnt_r == MAX_Q)) begin
                        // Window expired: report once and forget the previous owner.
                        state_nx_s            = ST_IDLE;
                        qcnt_nx_s             = {CNT_W{1'b0}};
                        fire_nx_s[FIRE_QUIET] = 1'b1;
                    end else begin
                        qcnt_nx_s = sat_inc(qcnt_r);
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    qcnt_nx_s  = {CNT_W{1'b0}};
                    owner_nx_s = {OW{1'b0}};
                end
            endcase
        end
        fire_nx_s[FIRE_XCHECK] = xz_s;
    end

    // State and output registers; enable low freezes everything but clears fire.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            qcnt_r        <= {CNT_W{1'b0}};
            owner_r       <= {OW{1'b0}};
            owner_valid_r <= 1'b0;
            fire_r        <= 3'b000;
            count_r       <= {CNT_W{1'b0}};
        end else if (enable) begin
            state_r       <= state_nx_s;
            qcnt_r        <= qcnt_nx_s;
            owner_r       <= owner_nx_s;
            owner_valid_r <= (state_nx_s == ST_OWNED);
            fire_r        <= fire_nx_s;
            count_r       <= (fire_nx_s != 3'b000) ? sat_inc(count_r) : count_r;
        end else begin
            fire_r <= 3'b000;
        end
    end

    assign fire            = fire_r;
    assign owner           = owner_r;
    assign owner_valid     = owner_valid_r;
    assign violation_count = count_r;

endmodule

// File: tb/tb_ovl_bus_contention_monitor.sv
// Directed bench for ovl_bus_contention_monitor (NUM_DRIVERS=4, WIDTH=8, MIN_QUIET=2, MAX_QUIET=5).
module tb_ovl_bus_contention_monitor;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [7:0]  test_expr;
    logic [3:0]  driver_enables;
    logic [2:0]  fire;
    logic [1:0]  owner;
    logic        owner_valid;
    logic [15:0] violation_count;

    int total = 0;
    int bad   = 0;

    ovl_bus_contention_monitor #(
        .NUM_DRIVERS (4),
        .WIDTH       (8),
        .MIN_QUIET   (2),
        .MAX_QUIET   (5)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .test_expr       (test_expr),
        .driver_enables  (driver_enables),
        .fire            (fire),
        .owner           (owner),
        .owner_valid     (owner_valid),
        .violation_count (violation_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input logic [3:0] de);
        driver_enables = de;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] f, input logic [1:0] o,
                           input logic ov, input logic [15:0] cnt);
        chk({tag, ".fire"},  {29'd0, fire}, {29'd0, f});
        chk({tag, ".owner"}, {30'd0, owner}, {30'd0, o});
        chk({tag, ".ovld"},  {31'd0, owner_valid}, {31'd0, ov});
        chk({tag, ".count"}, {16'd0, violation_count}, {16'd0, cnt});
    endtask

    initial begin
        reset          = 1'b0;
        enable         = 1'b1;
        test_expr      = 8'h00;
        driver_enables = 4'b0000;
        step(4'b0000);
        step(4'b0011);
        chk_all("reset", 3'b000, 2'd0, 1'b0, 16'd0);
        reset = 1'b1;

        // Contention straight after reset, persisting for two samples
        step(4'b0011);  chk_all("cont1", 3'b001, 2'd0, 1'b0, 16'd1);
        step(4'b0011);  chk_all("cont2", 3'b001, 2'd0, 1'b0, 16'd2);
        step(4'b0001);  chk_all("cont_to_own", 3'b000, 2'd0, 1'b1, 16'd2);

        // Short quiet: one idle cycle then grant to driver 2
        step(4'b0000);  chk_all("quiet1", 3'b000, 2'd0, 1'b0, 16'd2);
        step(4'b0100);  chk_all("short_quiet", 3'b010, 2'd2, 1'b1, 16'd3);

        // Direct handover without idle, then legal two-cycle handover
        step(4'b0001);  chk_all("no_gap", 3'b010, 2'd0, 1'b1, 16'd4);
        step(4'b0000);
        step(4'b0000);  chk_all("quiet2", 3'b000, 2'd0, 1'b0, 16'd4);
        step(4'b1000);  chk_all("legal_handover", 3'b000, 2'd3, 1'b1, 16'd4);

        // Re-grant to same owner after a too-short gap
        step(4'b0000);
        step(4'b1000);  chk_all("regrant_same", 3'b010, 2'd3, 1'b1, 16'd5);

        // Max quiet: five idle cycles are fine, the sixth expires the window
        step(4'b0010);  chk_all("own1", 3'b010, 2'd1, 1'b1, 16'd6);
        for (int i = 0; i < 5; i++) step(4'b0000);
        chk_all("quiet5", 3'b000, 2'd0, 1'b0, 16'd6);
        step(4'b0000);  chk_all("max_quiet", 3'b010, 2'd0, 1'b0, 16'd7);
        step(4'b0000);  chk_all("idle_after", 3'b000, 2'd0, 1'b0, 16'd7);
        step(4'b0001);  chk_all("grant_from_idle", 3'b000, 2'd0, 1'b1, 16'd7);

        // Enable low suppresses contention and holds state
        enable = 1'b0;
        step(4'b1100);  chk_all("disabled", 3'b000, 2'd0, 1'b1, 16'd7);
        enable = 1'b1;
        step(4'b1100);  chk_all("reenabled", 3'b001, 2'd0, 1'b0, 16'd8);

        // Reset mid-quiet discards the pending window
        step(4'b0000);
        reset = 1'b0;
        step(4'b0000);  chk_all("reset_mid_quiet", 3'b000, 2'd0, 1'b0, 16'd0);
        reset = 1'b1;
        step(4'b0001);  chk_all("after_reset", 3'b000, 2'd0, 1'b1, 16'd0);

        // X on the owned bus
        test_expr = 8'b0000_x000;
        step(4'b0001);
`ifdef OVL_BUS_XCHECK_EN
        chk_all("xcheck", 3'b100, 2'd0, 1'b1, 16'd1);
`else
        chk_all("xcheck", 3'b000, 2'd0, 1'b1, 16'd0);
`endif
        test_expr = 8'h5a;
        step(4'b0001);  chk("clean_bus.fire", {29'd0, fire}, 32'd0);

        // Violation counter saturation
        for (int i = 0; i < 65540; i++) step(4'b0011);
        chk("sat.count", {16'd0, violation_count}, 32'h0000_ffff);
        chk("sat.fire",  {29'd0, fire}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
